pcie_cfg_space_mf: RTL
======================

Name: pcie_cfg_space_mf

Overview:
- Parametrised multi-function Type-0 PCIe configuration space with an MSI capability and an MSI message generator.
- Serves config reads and writes from the host complex transaction layer, with one-cycle response latency.
- Collects per-function, per-vector interrupt pulses and issues MSI memory-write descriptors to the TL through a valid/ready handshake.

Parameters:
- NUM_FUNC, 2, number of functions (1..8).
- NUM_BAR, 2, 32-bit memory BARs per function (1..6).
- BAR_SIZE_LOG2, 12, log2 of BAR window bytes (4..31); same for all BARs.
- NUM_VEC, 4, MSI vectors per function (power of two, 1..32).
- VENDOR_ID, 16'h1AF4, read-only vendor ID.
- DEVICE_ID, 16'h0001, read-only device ID.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-low
- cfg_req  in  1  config access strobe; one access per cycle, back-to-back allowed
- cfg_we  in  1  1 = write, 0 = read
- cfg_func  in  FW  target function; FW = max(1, $clog2(NUM_FUNC))
- cfg_reg  in  10  dword register index
- cfg_be  in  4  write byte enables
- cfg_wdata  in  32  write data
- cfg_ack  out  1  response strobe, exactly 1 cycle after cfg_req
- cfg_rdata  out  32  read data, valid with cfg_ack (0 for writes)
- irq_req  in  NUM_FUNC*NUM_VEC  interrupt pulses, index f*NUM_VEC+v
- msi_valid  out  1  MSI descriptor valid
- msi_ready  in  1  TL accepts descriptor
- msi_addr  out  64  MSI address
- msi_data  out  16  MSI data
- msi_func  out  FW  originating function
- mem_en  out  NUM_FUNC  command bit 1 per function
- bus_master_en  out  NUM_FUNC  command bit 2 per function

Behaviour:
- Reset: all outputs 0; command, BARs, MSI registers and pending bits 0; arbiter pointer 0; FSM IDLE.
- Register map (dword index):
  - 0x00: {DEVICE_ID, VENDOR_ID}, RO.
  - 0x01: command. Writable bits 1, 2, 10; all other bits and status read 0.
  - 0x04..0x04+NUM_BAR-1: BARs. Bits [31:BAR_SIZE_LOG2] RW; bits [3:0] read 0000 (32-bit, non-prefetchable); the remaining low bits read 0.
  - 0x0D: cap pointer, reads 0x50.
  - 0x14: MSI header. [7:0]=0x05, [15:8]=0x00, bit16 enable RW, [19:17] MMC RO = log2(NUM_VEC), [22:20] MME RW, bit23 = 1 (64-bit capable).
  - 0x15: addr_lo, bits [31:2] RW, bits [1:0] read 0.
  - 0x16: addr_hi, RW.
  - 0x17: msg data, [15:0] RW.
  - All other indices read 0; writes to them are dropped.
- Writes honour cfg_be per byte.
- cfg_func >= NUM_FUNC: read returns 32'hFFFFFFFF; write dropped; ack still issued.
- MME write greater than MMC saturates to MMC.
- Pending: irq_req bit sets its pending bit the next cycle. Set and clear of the same bit in one cycle leaves it set.
- Pending persists while MSI enable or bus_master_en is 0.
- FSM states:
  - IDLE → ARB when any eligible pending bit exists (function has MSI enable = 1 and bus master = 1).
  - ARB: round-robin over functions starting at the pointer; lowest pending vector within the chosen function. Latch descriptor; go to SEND.
  - SEND: msi_valid held with stable addr/data/func until msi_ready. On the handshake, clear that pending bit, set pointer = f+1 (wrapping), return to IDLE.
- Latency: irq_req at cycle N gives msi_valid at N+3 at the earliest.
- Descriptor fields:
  - msi_addr = {addr_hi, addr_lo}.
  - Effective vector ve = min(v, 2^MME - 1).
  - msi_data = msg_data with its low MME bits replaced by ve.
  - A vector folded into ve clears only its own pending bit.
- A config write that disables MSI or bus master during SEND does not drop the in-flight descriptor.
- Reset mid-SEND: msi_valid drops asynchronously; pending is lost.

Optional Feature:
- Macro PCIE_CFG_MSI_MASK_EN.
- Defined:
  - Header bit24 reads 1 (per-vector masking capable).
  - 0x18 is a RW mask register over [NUM_VEC-1:0].
  - 0x19 is a RO pending register over [NUM_VEC-1:0].
  - Masked vectors stay pending but are not eligible; unmasking makes them eligible immediately.
- Undefined: bit24 reads 0; 0x18/0x19 read 0; no masking.

Decomposition:
- Package pcie_cfg_pkg: register index constants, MSI cap ID, command bit positions, cap pointer value, FSM state enum.
- Sub-module pcie_msi_arb: round-robin function select plus lowest-vector priority encode, combinational, with its pointer register.

Test Plan:
- After reset, read func0 idx 0x00 → ack one cycle later, rdata 32'h00011AF4; read idx 0x0D → 0x50; read func 3 (NUM_FUNC=2) → 32'hFFFFFFFF.
- Write BAR0 32'hFFFFFFFF → read 32'hFFFFF000; write be=4'b0001 data 0xFF to command → mem_en[0]=1, bus_master_en[0]=1.
- Func1: addr_lo 0xFEE00000, addr_hi 0, data 0x4020, MME=2, enable; pulse irq_req[5] → msi_valid at N+3, addr 0xFEE00000, data 0x4021, func 1; clear on ready.
- MME=1, pulse vector 3 → data low bit = 1; pending[3] cleared, pending[1] untouched.
- Both functions pending with msi_ready low 4 cycles → func0 held stable, then func1 next; pointer alternates.
- MSI disabled, pulse irq → no msi_valid for 20 cycles; enable → descriptor issued. With PCIE_CFG_MSI_MASK_EN: masked vector held until unmasked.

Source files
------------

// File: rtl/pcie_cfg_space_mf_pkg.sv
// Shared constants for the multi-function Type-0 config space with MSI:
// register indices, capability values, command bit positions, MSI FSM states.
package pcie_cfg_pkg;

    localparam logic [9:0] REG_ID       = 10'h000;
    localparam logic [9:0] REG_CMD      = 10'h001;
    localparam logic [9:0] REG_BAR0     = 10'h004;
    localparam logic [9:0] REG_CAPPTR   = 10'h00D;
    localparam logic [9:0] REG_MSI_HDR  = 10'h014;
    localparam logic [9:0] REG_MSI_ALO  = 10'h015;
    localparam logic [9:0] REG_MSI_AHI  = 10'h016;
    localparam logic [9:0] REG_MSI_DATA = 10'h017;
    localparam logic [9:0] REG_MSI_MASK = 10'h018;
    localparam logic [9:0] REG_MSI_PEND = 10'h019;

    localparam logic [7:0] MSI_CAP_ID = 8'h05;
    localparam logic [7:0] CAP_PTR    = 8'h50;

    localparam int CMD_MEM_BIT  = 1;
    localparam int CMD_BM_BIT   = 2;
    localparam int CMD_INTX_BIT = 10;

    // Encodings fixed explicitly to stay compatible with the legacy state values.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARB  = 2'd1,
        ST_SEND = 2'd2
    } msi_state_e;

endpackage

// File: rtl/pcie_cfg_space_mf_arb.sv
// MSI arbiter: round-robin function select from a pointer, lowest eligible
// vector within that function; pointer advances past the function just served.
module pcie_msi_arb #(
    parameter int NUM_FUNC = 2,
    parameter int NUM_VEC  = 4,
    parameter int FW       = 1,
    parameter int VW       = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_FUNC*NUM_VEC-1:0]  elig,
    input  logic                         adv,
    input  logic [FW-1:0]                adv_func,
    output logic                         any,
    output logic [FW-1:0]                sel_func,
    output logic [VW-1:0]                sel_vec
);
    import pcie_cfg_pkg::*;

    localparam logic [FW-1:0] LAST_F = FW'(NUM_FUNC - 1);

    logic [FW-1:0] ptr;
    int unsigned   fi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (adv) begin
            ptr <= (adv_func == LAST_F) ? '0 : adv_func + 1'b1;
        end
    end

    always_comb begin
        any      = 1'b0;
        sel_func = '0;
        sel_vec  = '0;
        fi       = 0;
        for (int unsigned k = 0; k < NUM_FUNC; k++) begin
            fi = 32'(ptr) + k;
            if (fi >= NUM_FUNC) fi = fi - NUM_FUNC;
            if (!any && (|elig[fi*NUM_VEC +: NUM_VEC])) begin
                any      = 1'b1;
                sel_func = FW'(fi);
                // Scan downward so the lowest set vector is the one kept.
                for (int unsigned v = NUM_VEC; v > 0; v--) begin
                    if (elig[fi*NUM_VEC + v - 1]) sel_vec = VW'(v - 1);
                end
            end
        end
    end

endmodule

// File: rtl/pcie_cfg_space_mf.sv
// Multi-function Type-0 config space with MSI capability and MSI generator.
// Optional per-vector masking (header bit24, regs 0x18/0x19) under PCIE_CFG_MSI_MASK_EN.
module pcie_cfg_space_mf
    import pcie_cfg_pkg::*;
#(
    parameter int          NUM_FUNC      = 2,
    parameter int          NUM_BAR       = 2,
    parameter int          BAR_SIZE_LOG2 = 12,
    parameter int          NUM_VEC       = 4,
    parameter logic [15:0] VENDOR_ID     = 16'h1AF4,
    parameter logic [15:0] DEVICE_ID     = 16'h0001,
    localparam int         FW            = (NUM_FUNC > 1) ? $clog2(NUM_FUNC) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cfg_req,
    input  logic                         cfg_we,
    input  logic [FW-1:0]                cfg_func,
    input  logic [9:0]                   cfg_reg,
    input  logic [3:0]                   cfg_be,
    input  logic [31:0]                  cfg_wdata,
    output logic                         cfg_ack,
    output logic [31:0]                  cfg_rdata,
    input  logic [NUM_FUNC*NUM_VEC-1:0]  irq_req,
    output logic                         msi_valid,
    input  logic                         msi_ready,
    output logic [63:0]                  msi_addr,
    output logic [15:0]                  msi_data,
    output logic [FW-1:0]                msi_func,
    output logic [NUM_FUNC-1:0]          mem_en,
    output logic [NUM_FUNC-1:0]          bus_master_en
);
    localparam int          VW       = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;
    localparam int          NIRQ     = NUM_FUNC * NUM_VEC;
    localparam logic [2:0]  MMC      = 3'($clog2(NUM_VEC));
    localparam logic [31:0] BAR_MASK = ~((32'h1 << BAR_SIZE_LOG2) - 32'h1);
`ifdef PCIE_CFG_MSI_MASK_EN
    localparam logic        MASK_CAP = 1'b1;
`else
    localparam logic        MASK_CAP = 1'b0;
`endif

    logic [NUM_FUNC-1:0] cmd_mem, cmd_bm, cmd_intx, msi_en;
    logic [31:0]         bar_q  [NUM_FUNC][NUM_BAR];
    logic [2:0]          mme_q  [NUM_FUNC];
    logic [29:0]         alo_q  [NUM_FUNC];
    logic [31:0]         ahi_q  [NUM_FUNC];
    logic [15:0]         mdat_q [NUM_FUNC];
`ifdef PCIE_CFG_MSI_MASK_EN
    logic [NUM_VEC-1:0]  mask_q [NUM_FUNC];
`endif
    logic [NIRQ-1:0]     pend_q, elig, clr;

    logic [FW-1:0]  fidx;
    logic           func_ok, wr, hs, arb_any;
    logic [31:0]    cur, wmask, merged;
    logic [2:0]     mme_wr;
    logic [FW-1:0]  sel_func;
    logic [VW-1:0]  sel_vec, d_vec;
    logic [15:0]    lo_m, ve, dat_n;
    msi_state_e     state_q;

    assign fidx          = cfg_func;
    assign func_ok       = 32'(cfg_func) < NUM_FUNC;
    assign wr            = cfg_req && cfg_we && func_ok;
    assign hs            = msi_valid && msi_ready;
    assign mem_en        = cmd_mem;
    assign bus_master_en = cmd_bm;

    always_comb begin
        cur = '0;
        if (cfg_reg == REG_ID) begin
            cur = {DEVICE_ID, VENDOR_ID};
        end else if (cfg_reg == REG_CMD) begin
            cur[CMD_MEM_BIT]  = cmd_mem[fidx];
            cur[CMD_BM_BIT]   = cmd_bm[fidx];
            cur[CMD_INTX_BIT] = cmd_intx[fidx];
        end else if (cfg_reg == REG_CAPPTR) begin
            cur = {24'h0, CAP_PTR};
        end else if (cfg_reg == REG_MSI_HDR) begin
            cur = {7'h0, MASK_CAP, 1'b1, mme_q[fidx], MMC, msi_en[fidx], 8'h00, MSI_CAP_ID};
        end else if (cfg_reg == REG_MSI_ALO) begin
            cur = {alo_q[fidx], 2'b00};
        end else if (cfg_reg == REG_MSI_AHI) begin
            cur = ahi_q[fidx];
        end else if (cfg_reg == REG_MSI_DATA) begin
            cur = {16'h0, mdat_q[fidx]};
`ifdef PCIE_CFG_MSI_MASK_EN
        end else if (cfg_reg == REG_MSI_MASK) begin
            cur = 32'(mask_q[fidx]);
        end else if (cfg_reg == REG_MSI_PEND) begin
            cur = 32'(pend_q[32'(fidx)*NUM_VEC +: NUM_VEC]);
`endif
        end
        for (int unsigned b = 0; b < NUM_BAR; b++) begin
            if (cfg_reg == REG_BAR0 + 10'(b)) cur = bar_q[fidx][b];
        end
    end

    // Byte-enable merge against the current readback; RO bits are then simply not stored.
    assign wmask  = {{8{cfg_be[3]}}, {8{cfg_be[2]}}, {8{cfg_be[1]}}, {8{cfg_be[0]}}};
    assign merged = (cur & ~wmask) | (cfg_wdata & wmask);
    assign mme_wr = (merged[22:20] > MMC) ? MMC : merged[22:20];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_ack   <= 1'b0;
            cfg_rdata <= '0;
        end else begin
            cfg_ack   <= cfg_req;
            cfg_rdata <= (cfg_req && !cfg_we) ? (func_ok ? cur : '1) : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_mem  <= '0;
            cmd_bm   <= '0;
            cmd_intx <= '0;
            msi_en   <= '0;
            for (int unsigned f = 0; f < NUM_FUNC; f++) begin
                for (int unsigned b = 0; b < NUM_BAR; b++) bar_q[f][b] <= '0;
                mme_q[f]  <= '0;
                alo_q[f]  <= '0;
                ahi_q[f]  <= '0;
                mdat_q[f] <= '0;
`ifdef PCIE_CFG_MSI_MASK_EN
                mask_q[f] <= '0;
`endif
            end
        end else if (wr) begin
            if (cfg_reg == REG_CMD) begin
                cmd_mem[fidx]  <= merged[CMD_MEM_BIT];
                cmd_bm[fidx]   <= merged[CMD_BM_BIT];
                cmd_intx[fidx] <= merged[CMD_INTX_BIT];
            end
            for (int unsigned b = 0; b < NUM_BAR; b++) begin
                if (cfg_reg == REG_BAR0 + 10'(b)) bar_q[fidx][b] <= merged & BAR_MASK;
            end
            if (cfg_reg == REG_MSI_HDR) begin
                msi_en[fidx] <= merged[16];
                mme_q[fidx]  <= mme_wr;
            end
            if (cfg_reg == REG_MSI_ALO)  alo_q[fidx]  <= merged[31:2];
            if (cfg_reg == REG_MSI_AHI)  ahi_q[fidx]  <= merged;
            if (cfg_reg == REG_MSI_DATA) mdat_q[fidx] <= merged[15:0];
`ifdef PCIE_CFG_MSI_MASK_EN
            if (cfg_reg == REG_MSI_MASK) mask_q[fidx] <= merged[NUM_VEC-1:0];
`endif
        end
    end

    always_comb begin
        elig = '0;
        for (int unsigned f = 0; f < NUM_FUNC; f++) begin
            for (int unsigned v = 0; v < NUM_VEC; v++) begin
                elig[f*NUM_VEC + v] = pend_q[f*NUM_VEC + v] && msi_en[f] && cmd_bm[f]
`ifdef PCIE_CFG_MSI_MASK_EN
                                      && !mask_q[f][v]
`endif
                                      ;
            end
        end
    end

    always_comb begin
        clr = '0;
        if (hs) clr[32'(msi_func)*NUM_VEC + 32'(d_vec)] = 1'b1;
    end

    // New pulses are OR-ed after the clear so a same-cycle set wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pend_q <= '0;
        else        pend_q <= (pend_q & ~clr) | irq_req;
    end

    pcie_msi_arb #(
        .NUM_FUNC (NUM_FUNC),
        .NUM_VEC  (NUM_VEC),
        .FW       (FW),
        .VW       (VW)
    ) u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .elig     (elig),
        .adv      (hs),
        .adv_func (msi_func),
        .any      (arb_any),
        .sel_func (sel_func),
        .sel_vec  (sel_vec)
    );

    assign lo_m  = (16'h1 << mme_q[sel_func]) - 16'h1;
    assign ve    = (16'(sel_vec) > lo_m) ? lo_m : 16'(sel_vec);
    assign dat_n = (mdat_q[sel_func] & ~lo_m) | (ve & lo_m);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            msi_valid <= 1'b0;
            msi_addr  <= '0;
            msi_data  <= '0;
            msi_func  <= '0;
            d_vec     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (arb_any) state_q <= ST_ARB;
                ST_ARB: begin
                    if (arb_any) begin
                        msi_addr  <= {ahi_q[sel_func], alo_q[sel_func], 2'b00};
                        msi_data  <= dat_n;
                        msi_func  <= sel_func;
                        d_vec     <= sel_vec;
                        msi_valid <= 1'b1;
                        state_q   <= ST_SEND;
                    end else begin
                        state_q   <= ST_IDLE;
                    end
                end
                ST_SEND: begin
                    if (msi_ready) begin
                        msi_valid <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
